// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-access stage: size codes, FSM states,
// byte-enable and alignment rules.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {IDLE, ACCESS} state_t;

    // Reserved size 2'b11 falls through to word.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 4'b0001 << off;
            SZ_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Request/acknowledge data-memory bus between the memory stage and the data memory.
interface mem_stage_if #(parameter int AW = 32);
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic [3:0]    dmem_be;
    logic          dmem_ack;
    logic [31:0]   dmem_rdata;

    modport master (output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                    input  dmem_ack, dmem_rdata);
    modport slave  (input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                    output dmem_ack, dmem_rdata);
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store replication / byte enables and
// load lane extraction with zero or sign extension.
module mem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_off,
    input  logic        i_signed,
    input  logic [31:0] i_st_data,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_wdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_ld_data
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign o_be   = byte_en(i_size, i_off);
    assign w_byte = i_rdata[8*i_off +: 8];
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_wdata   = i_st_data;
        o_ld_data = i_rdata;
        case (i_size)
            SZ_BYTE: begin
                o_wdata   = {4{i_st_data[7:0]}};
                o_ld_data = {{24{i_signed & w_byte[7]}}, w_byte};
            end
            SZ_HALF: begin
                o_wdata   = {2{i_st_data[15:0]}};
                o_ld_data = {{16{i_signed & w_half[15]}}, w_half};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues data-memory requests, freezes upstream while
// an access is outstanding, and loads the write-back register. Optional MEM_ALIGN_CHECK_EN.
module mem_stage
    import mem_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [DW-1:0] aluResult1_PR,
    input  logic [DW-1:0] readDataB1_PR,
    input  logic [4:0]    writeRegister1_PR,
    input  logic          do_writeback1_PR,
    input  logic          MemRead1_PR,
    input  logic          MemWrite1_PR,
    input  logic          MemtoReg1_PR,
    input  logic [1:0]    mem_size_PR,
    input  logic          mem_signed_PR,
    mem_stage_if.master   dmem,
    output logic          FREEZE,
    output logic [DW-1:0] Data1_MEM,
    output logic [4:0]    writeRegister1_MEM,
    output logic          do_writeback1_MEM,
    output logic [DW-1:0] Data1_WB,
    output logic [4:0]    writeRegister1_WB,
    output logic          do_writeback1_WB
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic          mem_misalign
`endif
);
    state_t        r_state, w_next;
    logic          r_req, r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          w_memop, w_issue, w_misalign;
    logic [31:0]   w_wdata, w_ld_data;
    logic [3:0]    w_be;

    assign w_memop = MemRead1_PR | MemWrite1_PR;
`ifdef MEM_ALIGN_CHECK_EN
    logic r_misalign;
    assign w_misalign   = w_memop && (r_state == IDLE) && misaligned(mem_size_PR, aluResult1_PR[1:0]);
    assign mem_misalign = r_misalign;
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_misalign <= 1'b0;
        else       r_misalign <= w_misalign;
    end
`else
    assign w_misalign = 1'b0;
`endif
    assign w_issue = w_memop & ~w_misalign;

    mem_lane_align u_lane (
        .i_size    (mem_size_PR),
        .i_off     (aluResult1_PR[1:0]),
        .i_signed  (mem_signed_PR),
        .i_st_data (readDataB1_PR),
        .i_rdata   (dmem.dmem_rdata),
        .o_wdata   (w_wdata),
        .o_be      (w_be),
        .o_ld_data (w_ld_data)
    );

    // FREEZE is masked by RESET so a reset mid-access releases upstream at once.
    always_comb begin
        w_next = r_state;
        FREEZE = 1'b0;
        case (r_state)
            IDLE: if (w_issue) begin
                w_next = ACCESS;
                FREEZE = 1'b1;
            end
            ACCESS: if (dmem.dmem_ack) w_next = IDLE;
                    else               FREEZE = 1'b1;
            default: w_next = IDLE;
        endcase
        if (RESET) FREEZE = 1'b0;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Request fields are captured once on entry and held for the whole access.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
        end else if (r_state == IDLE && w_issue) begin
            r_req   <= 1'b1;
            r_we    <= MemWrite1_PR;
            r_addr  <= {aluResult1_PR[AW-1:2], 2'b00};
            r_wdata <= w_wdata;
            r_be    <= w_be;
        end else if (r_state == ACCESS && dmem.dmem_ack) begin
            r_req   <= 1'b0;
            r_we    <= 1'b0;
        end
    end

    assign dmem.dmem_req   = r_req;
    assign dmem.dmem_we    = r_we;
    assign dmem.dmem_addr  = r_addr;
    assign dmem.dmem_wdata = r_wdata;
    assign dmem.dmem_be    = r_be;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            Data1_WB          <= '0;
            writeRegister1_WB <= '0;
            do_writeback1_WB  <= 1'b0;
        end else if (!FREEZE) begin
            Data1_WB          <= MemtoReg1_PR ? w_ld_data : aluResult1_PR;
            writeRegister1_WB <= writeRegister1_PR;
            do_writeback1_WB  <= do_writeback1_PR & ~w_misalign;
        end else begin
            do_writeback1_WB  <= 1'b0;
        end
    end

    assign Data1_MEM          = aluResult1_PR;
    assign writeRegister1_MEM = writeRegister1_PR;
    assign do_writeback1_MEM  = do_writeback1_PR & ~MemRead1_PR;
endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a rule-level reference model.
module tb_mem_stage;
    import mem_pkg::*;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
    logic mem_misalign;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RESET;
    logic [31:0] alu, bdata;
    logic [4:0]  wreg;
    logic        dowb, mrd, mwr, m2r, msgn;
    logic [1:0]  msz;
    logic        FREEZE, do_writeback1_MEM, do_writeback1_WB;
    logic [31:0] Data1_MEM, Data1_WB;
    logic [4:0]  writeRegister1_MEM, writeRegister1_WB;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_data;
    logic [4:0]  last_rd;
    bit          last_known;

    mem_stage_if #(.AW(32)) dif ();

    mem_stage #(.AW(32), .DW(32)) dut (
        .CLK (CLK), .RESET (RESET),
        .aluResult1_PR (alu), .readDataB1_PR (bdata), .writeRegister1_PR (wreg),
        .do_writeback1_PR (dowb), .MemRead1_PR (mrd), .MemWrite1_PR (mwr),
        .MemtoReg1_PR (m2r), .mem_size_PR (msz), .mem_signed_PR (msgn),
        .dmem (dif), .FREEZE (FREEZE),
        .Data1_MEM (Data1_MEM), .writeRegister1_MEM (writeRegister1_MEM),
        .do_writeback1_MEM (do_writeback1_MEM),
        .Data1_WB (Data1_WB), .writeRegister1_WB (writeRegister1_WB),
        .do_writeback1_WB (do_writeback1_WB)
`ifdef MEM_ALIGN_CHECK_EN
        , .mem_misalign (mem_misalign)
`endif
    );

    always #5 CLK = ~CLK;

    // Reference rules, written as arithmetic on the size/offset.
    function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] off);
        if (sz == 2'd0)      return 4'b0001 << off;
        else if (sz == 2'd1) return (off >= 2'd2) ? 4'd12 : 4'd3;
        else                 return 4'd15;
    endfunction

    function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] b);
        if (sz == 2'd0)      return {24'd0, b[7:0]} * 32'h0101_0101;
        else if (sz == 2'd1) return {16'd0, b[15:0]} * 32'h0001_0001;
        else                 return b;
    endfunction

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg,
                                             input logic [1:0] off, input logic [31:0] r);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (r >> (8 * off)) & 32'hFF;
            if (sg && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (r >> (off[1] ? 16 : 0)) & 32'hFFFF;
            if (sg && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = r;
        end
        return v;
    endfunction

    function automatic bit is_mis(input logic [1:0] sz, input logic [1:0] off);
        if (!ALIGN_EN)       return 1'b0;
        if (sz == 2'd0)      return 1'b0;
        else if (sz == 2'd1) return off[0];
        else                 return off != 2'd0;
    endfunction

    // One instruction through the stage; starts and ends just after a rising edge.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                         input logic wb, input logic mr, input logic mw, input logic lm,
                         input logic [1:0] sz, input logic sg, input int waits,
                         input logic [31:0] rdat);
        bit          memop, mis;
        int          fcnt;
        logic [31:0] exp_d;
        alu = a; bdata = b; wreg = rd; dowb = wb; mrd = mr; mwr = mw; m2r = lm;
        msz = sz; msgn = sg; dif.dmem_ack = 1'b0; dif.dmem_rdata = $urandom;
        memop = mr | mw;
        mis   = memop && is_mis(sz, a[1:0]);
        exp_d = lm ? exp_load(sz, sg, a[1:0], rdat) : a;
        @(negedge CLK);
        checks++;
        if (Data1_MEM !== a || writeRegister1_MEM !== rd || do_writeback1_MEM !== (wb & ~mr)) begin
            errors++;
            $display("FAIL fwd_view: got %h/%0d/%b want %h/%0d/%b", Data1_MEM, writeRegister1_MEM,
                     do_writeback1_MEM, a, rd, wb & ~mr);
        end
        if (memop && !mis) begin
            checks++;
            if (FREEZE !== 1'b1 || dif.dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL idle_cycle: got freeze=%b req=%b want freeze=1 req=0", FREEZE, dif.dmem_req);
            end
            fcnt = 1;
            @(posedge CLK); #1;
            for (int i = 0; i <= waits; i++) begin
                dif.dmem_ack   = (i == waits);
                dif.dmem_rdata = (i == waits) ? rdat : $urandom;
                @(negedge CLK);
                if (FREEZE === 1'b1) fcnt++;
                checks++;
                if (FREEZE !== (i != waits)) begin
                    errors++;
                    $display("FAIL access_freeze: got %b want %b (cycle %0d)", FREEZE, i != waits, i);
                end
                checks++;
                if (dif.dmem_req !== 1'b1 || dif.dmem_we !== mw || dif.dmem_addr !== (a & ~32'd3) ||
                    dif.dmem_be !== exp_be(sz, a[1:0]) || dif.dmem_wdata !== exp_wdata(sz, b)) begin
                    errors++;
                    $display("FAIL request: got req=%b we=%b addr=%h be=%b wd=%h want 1 %b %h %b %h",
                             dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_be, dif.dmem_wdata,
                             mw, a & ~32'd3, exp_be(sz, a[1:0]), exp_wdata(sz, b));
                end
                checks++;
                if (do_writeback1_WB !== 1'b0 ||
                    (last_known && (Data1_WB !== last_data || writeRegister1_WB !== last_rd))) begin
                    errors++;
                    $display("FAIL bubble_hold: got wb=%b d=%h rd=%0d want wb=0 d=%h rd=%0d",
                             do_writeback1_WB, Data1_WB, writeRegister1_WB, last_data, last_rd);
                end
                @(posedge CLK); #1;
            end
            dif.dmem_ack = 1'b0;
            checks++;
            if (dif.dmem_req !== 1'b0 || fcnt != waits + 1) begin
                errors++;
                $display("FAIL req_drop_latency: got req=%b freeze_cycles=%0d want 0 %0d",
                         dif.dmem_req, fcnt, waits + 1);
            end
        end else begin
            checks++;
            if (FREEZE !== 1'b0 || dif.dmem_req !== 1'b0) begin
                errors++;
                $display("FAIL nonissue: got freeze=%b req=%b want 0 0", FREEZE, dif.dmem_req);
            end
            @(posedge CLK); #1;
        end
        if (mis) begin
            checks++;
            if (do_writeback1_WB !== 1'b0) begin
                errors++;
                $display("FAIL misalign_wb: got %b want 0", do_writeback1_WB);
            end
`ifdef MEM_ALIGN_CHECK_EN
            checks++;
            if (mem_misalign !== 1'b1) begin
                errors++;
                $display("FAIL misalign_flag: got %b want 1", mem_misalign);
            end
`endif
            last_known = 1'b0;
        end else begin
            checks++;
            if (Data1_WB !== exp_d || writeRegister1_WB !== rd || do_writeback1_WB !== wb) begin
                errors++;
                $display("FAIL wb_reg: got %h/%0d/%b want %h/%0d/%b", Data1_WB, writeRegister1_WB,
                         do_writeback1_WB, exp_d, rd, wb);
            end
            last_data = exp_d; last_rd = rd; last_known = 1'b1;
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        alu = '0; bdata = '0; wreg = '0; dowb = 0; mrd = 0; mwr = 0; m2r = 0; msz = '0; msgn = 0;
        dif.dmem_ack = 1'b0; dif.dmem_rdata = '0;
        #12;
        checks++;
        if (dif.dmem_req !== 1'b0 || dif.dmem_we !== 1'b0 || dif.dmem_addr !== 32'd0 ||
            dif.dmem_wdata !== 32'd0 || dif.dmem_be !== 4'd0 || FREEZE !== 1'b0 ||
            Data1_WB !== 32'd0 || writeRegister1_WB !== 5'd0 || do_writeback1_WB !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got req=%b addr=%h be=%b freeze=%b wb=%h/%0d/%b want all 0",
                     dif.dmem_req, dif.dmem_addr, dif.dmem_be, FREEZE, Data1_WB,
                     writeRegister1_WB, do_writeback1_WB);
        end
        @(posedge CLK); #1;
        RESET = 1'b0;
        last_data = '0; last_rd = '0; last_known = 1'b1;
    endtask

    task automatic test_directed();
        do_op(32'h0000_1234, 32'h0, 5'd5, 1, 0, 0, 0, SZ_WORD, 0, 0, 32'h0);
        do_op(32'h0000_0100, 32'h0, 5'd6, 1, 1, 0, 1, SZ_WORD, 0, 3, 32'hDEAD_BEEF);
        do_op(32'h0000_0103, 32'h0, 5'd7, 1, 1, 0, 1, SZ_BYTE, 1, 0, 32'h8000_0000);
        do_op(32'h0000_0103, 32'h0, 5'd8, 1, 1, 0, 1, SZ_BYTE, 0, 1, 32'h8000_0000);
        do_op(32'h0000_0202, 32'h0000_ABCD, 5'd0, 0, 0, 1, 0, SZ_HALF, 0, 2, 32'h0);
        do_op(32'h0000_0206, 32'h0, 5'd9, 1, 1, 0, 1, SZ_HALF, 1, 0, 32'h9234_5678);
        do_op(32'h0000_0204, 32'h0, 5'd10, 1, 1, 0, 1, SZ_HALF, 1, 0, 32'h1234_8765);
    endtask

    task automatic test_ack_idle();
        alu = 32'h0000_0777; wreg = 5'd11; dowb = 1; mrd = 0; mwr = 0; m2r = 0;
        dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hFFFF_FFFF;
        @(negedge CLK);
        checks++;
        if (FREEZE !== 1'b0 || dif.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle: got freeze=%b req=%b want 0 0", FREEZE, dif.dmem_req);
        end
        @(posedge CLK); #1;
        dif.dmem_ack = 1'b0;
        checks++;
        if (Data1_WB !== 32'h0000_0777 || do_writeback1_WB !== 1'b1 || dif.dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL ack_idle_wb: got %h/%b req=%b want 00000777/1 req=0",
                     Data1_WB, do_writeback1_WB, dif.dmem_req);
        end
        last_data = 32'h0000_0777; last_rd = 5'd11; last_known = 1'b1;
    endtask

    task automatic test_back_to_back();
        do_op(32'h0000_0040, 32'h1122_3344, 5'd0, 0, 0, 1, 0, SZ_WORD, 0, 0, 32'h0);
        do_op(32'h0000_0041, 32'h0, 5'd12, 1, 1, 0, 1, SZ_BYTE, 0, 0, 32'h0000_5A00);
        do_op(32'h0000_0044, 32'h0, 5'd13, 1, 1, 0, 1, SZ_WORD, 0, 0, 32'hCAFE_F00D);
    endtask

    task automatic test_reset_mid_access();
        alu = 32'h0000_0300; wreg = 5'd14; dowb = 1; mrd = 1; mwr = 0; m2r = 1; msz = SZ_WORD;
        dif.dmem_ack = 1'b0;
        @(posedge CLK); #1;
        checks++;
        if (dif.dmem_req !== 1'b1 || FREEZE !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_access: got req=%b freeze=%b want 1 1", dif.dmem_req, FREEZE);
        end
        RESET = 1'b1;
        #1;
        checks++;
        if (dif.dmem_req !== 1'b0 || FREEZE !== 1'b0 || Data1_WB !== 32'd0 ||
            writeRegister1_WB !== 5'd0 || do_writeback1_WB !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: got req=%b freeze=%b wb=%h/%0d/%b want all 0",
                     dif.dmem_req, FREEZE, Data1_WB, writeRegister1_WB, do_writeback1_WB);
        end
        mrd = 0; mwr = 0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        last_data = '0; last_rd = '0; last_known = 1'b1;
        do_op(32'h0000_0300, 32'h0, 5'd15, 1, 1, 0, 1, SZ_WORD, 0, 1, 32'h0BAD_CAFE);
    endtask

    task automatic test_misalign();
        do_op(32'h0000_0101, 32'h0, 5'd16, 1, 1, 0, 1, SZ_WORD, 0, 0, 32'h1357_9BDF);
        do_op(32'h0000_0055, 32'h0, 5'd17, 1, 0, 0, 0, SZ_WORD, 0, 0, 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        checks++;
        if (mem_misalign !== 1'b0) begin
            errors++;
            $display("FAIL misalign_pulse: got %b want 0", mem_misalign);
        end
`endif
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a, b, r;
            logic [4:0]  rd;
            logic [1:0]  sz;
            logic        sg;
            int          k, w;
            a = $urandom; b = $urandom; r = $urandom;
            rd = 5'($urandom_range(0, 31)); sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1)); w = $urandom_range(0, 4); k = $urandom_range(0, 2);
            if (k == 0)      do_op(a, b, rd, 1, 0, 0, 0, sz, sg, 0, r);
            else if (k == 1) do_op(a, b, rd, 1, 1, 0, 1, sz, sg, w, r);
            else             do_op(a, b, rd, 0, 0, 1, 0, sz, sg, w, r);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ack_idle();
        test_back_to_back();
        test_reset_mid_access();
        test_misalign();
        test_random();
        mrd = 0; mwr = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage; consumes its pipeline register (ALU result, store data, destination, control).
- Drives a request/acknowledge data-memory port: byte lane steering, load extraction and sign extension.
- Freezes upstream stages while an access is outstanding.
- Registers results into the write-back pipeline register and exposes current-stage values for forwarding.

Parameters:
- AW, 32, data-memory address width.
- DW, 32, data width; fixed at 32 (lane logic assumes 4 bytes).

Ports:
- CLK  in  1  clock; all state on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- aluResult1_PR  in  32  effective address (mem op) or ALU result (non-mem op).
- readDataB1_PR  in  32  store data.
- writeRegister1_PR  in  5  destination register.
- do_writeback1_PR  in  1  instruction writes a register.
- MemRead1_PR  in  1  load.
- MemWrite1_PR  in  1  store.
- MemtoReg1_PR  in  1  write-back source is memory.
- mem_size_PR  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word).
- mem_signed_PR  in  1  sign-extend sub-word loads.
- dmem_req  out  1  request valid.
- dmem_we  out  1  write enable.
- dmem_addr  out  AW  word-aligned address (low 2 bits zero).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  32  read data, valid with dmem_ack.
- FREEZE  out  1  stall upstream stages and hold this stage's inputs.
- Data1_MEM, writeRegister1_MEM, do_writeback1_MEM  out  32/5/1  forwarding view of the current stage (combinational).
- Data1_WB, writeRegister1_WB, do_writeback1_WB  out  32/5/1  write-back pipeline register.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; dmem_req, dmem_we = 0; dmem_addr, dmem_wdata = 0; dmem_be = 0.
  - Data1_WB = 0; writeRegister1_WB = 0; do_writeback1_WB = 0.
- States:
  - IDLE → ACCESS when MemRead1_PR|MemWrite1_PR; request outputs are registered on that edge.
  - ACCESS → IDLE on the cycle dmem_ack is high.
- Request stability: dmem_req/we/addr/wdata/be held constant throughout ACCESS; dmem_req drops the cycle after ack.
- FREEZE = (IDLE & memop) | (ACCESS & !dmem_ack); combinational.
- Latency:
  - Non-memory op: 1 cycle, no freeze.
  - Memory op: minimum 2 cycles (IDLE + ACCESS with immediate ack); each extra wait cycle adds one.
- WB register load:
  - Loads every cycle FREEZE=0; on the ack cycle it takes the load result or store completion.
  - When FREEZE=1, do_writeback1_WB loads 0 (bubble); Data1_WB and writeRegister1_WB hold.
- Data1_WB source: extracted load data if MemtoReg1_PR, else aluResult1_PR.
- Store lanes:
  - Byte: wdata = {4{b[7:0]}}, be = 1<<addr[1:0].
  - Half: wdata = {2{b[15:0]}}, be = addr[1] ? 1100 : 0011.
  - Word: wdata = b, be = 1111.
- Loads: be as for stores, dmem_we = 0.
- Load extraction: select lane by addr[1:0] (half uses addr[1]); zero- or sign-extend per mem_signed_PR.
- Forwarding view: Data1_MEM = aluResult1_PR; do_writeback1_MEM = do_writeback1_PR & !MemRead1_PR. Load data is forwarded only from WB.
- ack while IDLE: ignored.
- Back-to-back memory ops: the next op re-enters ACCESS only after one IDLE cycle.
- Reset mid-ACCESS: request abandoned, dmem_req=0 immediately; memory tolerates a dropped request.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Enabled:
  - Adds output mem_misalign (1 bit, registered, reset 0).
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0) is not issued and stays in IDLE; FREEZE=0.
  - mem_misalign pulses 1 for one cycle; do_writeback1_WB loads 0.
- Disabled: no port; offending low address bits are ignored per the lane rules above.

Decomposition:
- Shared package mem_pkg:
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - State enum: IDLE, ACCESS.
  - Byte-enable function.
- One sub-module, mem_lane_align: combinational store replicate/byte-enable and load extract/extend. mem_stage keeps the FSM and registers.

Test Plan:
- Non-mem op, aluResult1_PR=0x0000_1234, wb=1, rd=5 → next edge Data1_WB=0x1234, writeRegister1_WB=5, do_writeback1_WB=1; FREEZE never 1.
- Word load addr 0x100, ack after 3 wait cycles, rdata 0xDEAD_BEEF → FREEZE high 4 cycles; dmem_addr 0x100 and be 1111 stable; Data1_WB=0xDEAD_BEEF after ack edge; bubble (do_writeback1_WB=0) during freeze.
- Signed byte load addr 0x103, rdata 0x80_00_00_00 → Data1_WB=0xFFFF_FF80; unsigned variant → 0x0000_0080.
- Half store addr 0x202, data 0x0000_ABCD → dmem_addr 0x200, be 1100, wdata 0xABCD_ABCD, we=1.
- RESET asserted during ACCESS → same cycle dmem_req=0, FREEZE=0, all WB outputs 0; release → next load issues normally.
- MEM_ALIGN_CHECK_EN: word load addr 0x101 → no dmem_req; mem_misalign=1 for one cycle; do_writeback1_WB=0.
